frame_buf_ctrl: RTL and testbench

Frame-buffer controller for the camera peripheral: it sequences one-shot frame captures from the camera pixel stream into the single-port frame RAM, and it shares that RAM's one port between camera writes and J1 CPU pixel reads. It sits between the capture block, the frame RAM and the peripheral address decoder. It runs entirely on the camera pixel clock domain.

---
 rtl/frame_buf_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_frame_buf_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buf_ctrl.sv
// frame_buf_ctrl: one-shot frame capture from the camera pixel stream into the
// single-port frame RAM, sharing that port with CPU pixel reads. Camera writes
// always own the port; a CPU read waits for the first write-free cycle.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | no capture; waiting for cmd_start
// ST_ARM     | camera enabled, waiting for the vsync falling edge (frame start)
// ST_CAPTURE | every pixel_valid is written at the write pointer
// ST_DONE    | frame complete; late pixels only raise overflow
module frame_buf_ctrl #(
  parameter int FRAME_PIXELS = 76800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic        cmd_abort,
  input  logic        vsync,
  input  logic        pixel_valid,
  input  logic [23:0] pixel_data,
  input  logic        rd_req,
  input  logic [16:0] rd_addr,
  output logic        rd_ack,
  output logic [23:0] rd_data,
  output logic        ram_en,
  output logic        ram_rw,
  output logic [16:0] ram_addr,
  output logic [23:0] ram_wdata,
  input  logic [23:0] ram_rdata,
  output logic        cam_enable,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [16:0] pix_count
);

  localparam logic [16:0] FP_MAX  = 17'(FRAME_PIXELS);
  localparam logic [16:0] FP_LAST = 17'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        vsync_d;
  logic [16:0] wr_ptr;

  logic        start_go;
  logic        wr_go;
  logic        vsync_fall;
  logic        vsync_rise;
  logic        enter_done;

  // read tracking: armed = rd_req seen low since the last ack
  logic        rd_armed;
  logic        rd_pend;
  logic        rd_issued;
  logic        rd_issued_oor;
  logic        rd_ack_oor;
  logic        rd_take;
  logic        rd_want;
  logic        rd_go;
  logic        rd_in_range;

  assign vsync_fall = vsync_d & ~vsync;
  assign vsync_rise = ~vsync_d & vsync;

  // abort beats start when both arrive together
  assign start_go = cmd_start & ~cmd_abort & ((state == ST_IDLE) | (state == ST_DONE));
  assign wr_go    = pixel_valid & ~cmd_abort & (state == ST_CAPTURE);
  assign enter_done = (state == ST_CAPTURE) & (state_nxt == ST_DONE);

  assign rd_take     = rd_req & rd_armed & ~rd_pend & ~rd_issued;
  assign rd_want     = rd_take | rd_pend;
  assign rd_go       = rd_want & ~wr_go;
  assign rd_in_range = (rd_addr < FP_MAX);

  // write pointer doubles as the CPU-visible pixel count
  assign pix_count = wr_ptr;

  // rd_data is only non-zero during the ack cycle, when the RAM output is valid
  assign rd_data = (rd_ack && !rd_ack_oor) ? ram_rdata : 24'd0;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state and state-decoded outputs
  always_comb begin
    state_nxt  = state;
    cam_enable = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_start) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        cam_enable = 1'b1;
        busy       = 1'b1;
        if (vsync_fall) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        cam_enable = 1'b1;
        busy       = 1'b1;
        // the pixel that brings the count to a full frame is still written
        if ((pixel_valid && (wr_ptr == FP_LAST)) || vsync_rise) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (cmd_start) state_nxt = ST_ARM;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (cmd_abort) state_nxt = ST_IDLE;
  end

  // vsync edge detector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_d <= 1'b0;
    end else begin
      vsync_d <= vsync;
    end
  end

  // write pointer, done and overflow flags; abort leaves them untouched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= 17'd0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else if (start_go) begin
      wr_ptr   <= 17'd0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_go) wr_ptr <= wr_ptr + 17'd1;
      if (enter_done) done <= 1'b1;
      if ((state == ST_DONE) && pixel_valid) overflow <= 1'b1;
    end
  end

  // RAM port: camera write has priority, otherwise a pending in-range read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_en    <= 1'b0;
      ram_rw    <= 1'b0;
      ram_addr  <= 17'd0;
      ram_wdata <= 24'd0;
    end else if (wr_go) begin
      ram_en    <= 1'b1;
      ram_rw    <= 1'b1;
      ram_addr  <= wr_ptr;
      ram_wdata <= pixel_data;
    end else if (rd_go && rd_in_range) begin
      ram_en    <= 1'b1;
      ram_rw    <= 1'b0;
      ram_addr  <= rd_addr;
    end else begin
      ram_en    <= 1'b0;
      ram_rw    <= 1'b0;
    end
  end

  // read sequencing: accept, wait out writes, issue, ack one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_armed      <= 1'b1;
      rd_pend       <= 1'b0;
      rd_issued     <= 1'b0;
      rd_issued_oor <= 1'b0;
      rd_ack        <= 1'b0;
      rd_ack_oor    <= 1'b0;
    end else begin
      rd_pend       <= rd_want & ~rd_go;
      rd_issued     <= rd_go;
      rd_issued_oor <= rd_go & ~rd_in_range;
      rd_ack        <= rd_issued;
      rd_ack_oor    <= rd_issued_oor;
      if (!rd_req) begin
        rd_armed <= 1'b1;
      end else if (rd_issued) begin
        rd_armed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Bench for frame_buf_ctrl: small frame size, random pixel data and gaps,
// a behavioural RAM, and an expected-contents image kept per pixel index.
module tb_frame_buf_ctrl;

  localparam int FP = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start, cmd_abort, vsync, pixel_valid;
  logic [23:0] pixel_data;
  logic        rd_req;
  logic [16:0] rd_addr;
  logic        rd_ack;
  logic [23:0] rd_data;
  logic        ram_en, ram_rw;
  logic [16:0] ram_addr;
  logic [23:0] ram_wdata;
  logic [23:0] ram_rdata;
  logic        cam_enable, busy, done, overflow;
  logic [16:0] pix_count;

  frame_buf_ctrl #(.FRAME_PIXELS(FP)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .vsync(vsync), .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .cam_enable(cam_enable), .busy(busy), .done(done),
    .overflow(overflow), .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [23:0] ram_mem [0:131071];
  logic [23:0] exp_mem [0:131071];
  int m_count;
  logic m_over;

  int wr_cnt = 0, en_cnt = 0, ack_cnt = 0, bad_wr_addr = 0, bad_wr_data = 0;

  // single-port synchronous RAM, read data one cycle after the access
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_rw) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  // port monitor: every write must land inside the frame with the sent pixel
  always @(negedge clk) begin
    if (rst) begin
      if (ram_en) en_cnt++;
      if (rd_ack) ack_cnt++;
      if (ram_en && ram_rw) begin
        wr_cnt++;
        if (ram_addr >= 17'(FP)) bad_wr_addr++;
        else if (ram_wdata !== exp_mem[ram_addr]) bad_wr_data++;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd();
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    m_count = 0;
    m_over  = 1'b0;
  endtask

  task automatic vsync_fall();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
  endtask

  task automatic send_pixel(input logic [23:0] d, input bit cap);
    pixel_data  = d;
    pixel_valid = 1'b1;
    if (cap) begin
      if (m_count < FP) begin
        exp_mem[m_count] = d;
        m_count++;
      end else begin
        m_over = 1'b1;
      end
    end
    step();
    pixel_valid = 1'b0;
  endtask

  task automatic send_n(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send_pixel(24'($urandom), 1'b1);
      if (gaps && ($urandom_range(0, 2) == 0)) step();
    end
  endtask

  task automatic do_read(input string tag, input logic [16:0] a, input bit chk_lat);
    logic [23:0] got;
    logic [23:0] exp;
    int lat;
    bit seen;
    exp = (a < 17'(FP)) ? exp_mem[a] : 24'd0;
    rd_req  = 1'b1;
    rd_addr = a;
    lat  = 0;
    seen = 0;
    got  = 24'd0;
    while (!seen && lat < 300) begin
      step();
      lat++;
      if (rd_ack) begin
        seen = 1;
        got  = rd_data;
      end
    end
    rd_req = 1'b0;
    check_val({tag, "_ack"}, 32'(seen), 32'd1);
    check_val({tag, "_data"}, 32'(got), 32'(exp));
    if (chk_lat) check_val({tag, "_lat"}, lat, 2);
    step();
  endtask

  logic        a_en [8];
  logic        a_rw [8];
  logic [16:0] a_ad [8];
  logic        a_ack[8];
  logic [23:0] a_dat[8];

  initial begin
    int w0, e0, k0, ack_late;
    rst = 1'b0; cmd_start = 0; cmd_abort = 0; vsync = 1'b1; pixel_valid = 0;
    pixel_data = 24'd0; rd_req = 0; rd_addr = 17'd0;
    m_count = 0; m_over = 0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_outputs",
              {ram_en, ram_rw, rd_ack, cam_enable, busy, done, overflow},
              7'd0);
    check_val("rst_ram_addr", 32'(ram_addr), 0);
    check_val("rst_ram_wdata", 32'(ram_wdata), 0);
    check_val("rst_rd_data", 32'(rd_data), 0);
    check_val("rst_pix_count", 32'(pix_count), 0);
    rst = 1'b1;
    step();

    // frame 1: full frame with random gaps
    start_cmd();
    check_val("f1_arm", {cam_enable, busy, done}, 3'b110);
    w0 = wr_cnt;
    for (int i = 0; i < 3; i++) send_pixel(24'($urandom), 1'b0);
    check_val("arm_ignores_pix", 32'(pix_count) + 32'(wr_cnt - w0), 0);
    vsync_fall();
    send_n(20, 1'b1);
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    check_val("start_in_capture", {busy, 15'd0, pix_count}, {1'b1, 15'd0, 17'd20});
    send_n(FP - 21, 1'b1);
    check_val("f1_before_last", {busy, done, 13'd0, pix_count}, {2'b10, 13'd0, 17'(FP - 1)});
    send_pixel(24'($urandom), 1'b1);
    check_val("f1_done", {busy, done, overflow, cam_enable}, 4'b0100);
    check_val("f1_pix_count", 32'(pix_count), 32'(m_count));
    do_read("rd0", 17'd0, 1'b1);
    do_read("rd37", 17'd37, 1'b1);
    do_read("rd_last", 17'(FP - 1), 1'b1);

    // frame 2: arbitration then short frame ended by vsync
    vsync = 1'b1;
    start_cmd();
    check_val("f2_cleared", {done, 15'd0, pix_count}, 0);
    vsync_fall();
    send_n(10, 1'b0);
    for (int c = 0; c < 8; c++) begin
      rd_req  = 1'b1;
      rd_addr = 17'd5;
      if (c < 3) begin
        pixel_valid = 1'b1;
        pixel_data  = 24'($urandom);
        exp_mem[m_count] = pixel_data;
        m_count++;
      end else begin
        pixel_valid = 1'b0;
      end
      step();
      a_en[c] = ram_en; a_rw[c] = ram_rw; a_ad[c] = ram_addr;
      a_ack[c] = rd_ack; a_dat[c] = rd_data;
    end
    rd_req = 1'b0;
    step();
    for (int c = 0; c < 3; c++)
      check_val("arb_write", {a_en[c], a_rw[c], a_ack[c], 12'd0, a_ad[c]},
                {3'b110, 12'd0, 17'(10 + c)});
    check_val("arb_read_issue", {a_en[3], a_rw[3], a_ack[3], 12'd0, a_ad[3]},
              {3'b100, 12'd0, 17'd5});
    check_val("arb_ack", 32'(a_ack[4]), 1);
    check_val("arb_data", 32'(a_dat[4]), 32'(exp_mem[5]));
    check_val("arb_single_ack", 32'(a_ack[5]) + 32'(a_ack[6]) + 32'(a_ack[7]), 0);
    send_n(100 - m_count, 1'b1);
    vsync = 1'b1;
    step();
    check_val("short_done", {busy, done, overflow}, 3'b010);
    check_val("short_count", 32'(pix_count), 100);
    do_read("rd99", 17'd99, 1'b1);
    do_read("rd110_old", 17'd110, 1'b1);

    // frame 3: overflow past a full frame
    start_cmd();
    vsync_fall();
    send_n(FP + 2, 1'b0);
    check_val("ovf_count", 32'(pix_count), FP);
    check_val("ovf_flags", {done, overflow}, {1'b1, m_over});

    // frame 4: abort mid-frame, then start+abort together
    vsync = 1'b1;
    start_cmd();
    vsync_fall();
    send_n(50, 1'b1);
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
    check_val("abort_flags", {busy, cam_enable, done, overflow}, 4'b0000);
    check_val("abort_count", 32'(pix_count), 50);
    cmd_start = 1'b1; cmd_abort = 1'b1;
    step();
    cmd_start = 1'b0; cmd_abort = 1'b0;
    step();
    check_val("start_abort_idle", {busy, cam_enable, 13'd0, pix_count}, {2'b00, 13'd0, 17'd50});

    // out-of-range reads never touch the RAM
    e0 = en_cnt;
    do_read("oor80000", 17'd80000, 1'b1);
    do_read("oor_fp", 17'(FP), 1'b1);
    check_val("oor_no_ram", en_cnt - e0, 0);

    // a request held high yields exactly one ack
    k0 = ack_cnt;
    rd_req = 1'b1;
    rd_addr = 17'd7;
    repeat (6) step();
    rd_req = 1'b0;
    step();
    check_val("held_req_one_ack", ack_cnt - k0, 1);

    for (int i = 0; i < 12; i++)
      do_read("rand_rd", 17'($urandom_range(0, FP + 15)), 1'b1);

    // reset with a read in flight during capture
    vsync = 1'b1;
    start_cmd();
    vsync_fall();
    send_n(8, 1'b0);
    rd_req = 1'b1;
    rd_addr = 17'd3;
    step();
    check_val("inflight_issued", {ram_en, ram_rw}, 2'b10);
    #1;
    rst = 1'b0;
    #1;
    check_val("midrst_outputs",
              {ram_en, ram_rw, rd_ack, cam_enable, busy, done, overflow}, 7'd0);
    check_val("midrst_values", {7'd0, ram_addr, 8'd0}, 32'd0);
    check_val("midrst_count_data", {pix_count, 15'd0} | 32'(rd_data) | 32'(ram_wdata), 0);
    rd_req = 1'b0;
    k0 = ack_cnt;
    ack_late = 0;
    repeat (2) step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rd_ack) ack_late++;
    end
    check_val("midrst_no_ack", ack_late + (ack_cnt - k0), 0);
    check_val("midrst_idle", {busy, cam_enable}, 2'b00);
    start_cmd();
    check_val("midrst_restart", {busy, cam_enable}, 2'b11);

    check_val("wr_addr_in_frame", bad_wr_addr, 0);
    check_val("wr_data_match", bad_wr_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
